univ_shift_reg: RTL and testbench

//  Parametrised universal register: parallel load, sync clear, and multi-cycle

---
 rtl/usr_pkg.sv | 24 ++
 rtl/usr_bit_cell.sv | 38 +++
 rtl/univ_shift_reg.sv | 147 ++++++++++++++
 tb/tb_univ_shift_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode, state and cell-select encodings for univ_shift_reg
package usr_pkg;

  localparam logic [2:0] MODE_SHL = 3'b000;
  localparam logic [2:0] MODE_SHR = 3'b001;
  localparam logic [2:0] MODE_ROL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_LOAD   = 3'd1,
    SEL_FROM_R = 3'd2,
    SEL_FROM_L = 3'd3,
    SEL_CLR    = 3'd4
  } sel_e;

endpackage

// File: rtl/usr_bit_cell.sv
// rtl/usr_bit_cell.sv - one register bit with hold/load/neighbour/clear select
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  sel_e sel_i,
  input  logic d_i,
  input  logic from_r_i,
  input  logic from_l_i,
  output logic q_o
);

  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    case (sel_i)
      SEL_LOAD:   bit_d = d_i;
      SEL_FROM_R: bit_d = from_r_i;
      SEL_FROM_L: bit_d = from_l_i;
      SEL_CLR:    bit_d = 1'b0;
      default:    bit_d = bit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal load/clear/shift/rotate register, one step per clock
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] shamt,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         mode_q;
  logic               sout_q;
  logic               sout_d;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   cell_q;
  sel_e               sel;
  logic               edge_r;
  logic               edge_l;

  // Edge bits: what enters bit 0 on a left move and bit WIDTH-1 on a right move.
  always_comb begin
    edge_r = sin_r;
    edge_l = sin_l;
    sout_d = sout_q;
    sel    = SEL_HOLD;
    case (mode_q)
      MODE_ROL: edge_r = cell_q[WIDTH-1];
      MODE_ROR: edge_l = cell_q[0];
      MODE_ASR: edge_l = cell_q[WIDTH-1];
      default:  ;
    endcase
    if (clr) begin
      sel = SEL_CLR;
    end else if (state_q == ST_IDLE && ld) begin
      sel = SEL_LOAD;
    end else if (state_q == ST_SHIFT) begin
      case (mode_q)
        MODE_SHL, MODE_ROL: begin
          sel    = SEL_FROM_R;
          sout_d = cell_q[WIDTH-1];
        end
        MODE_SHR, MODE_ROR, MODE_ASR: begin
          sel    = SEL_FROM_L;
          sout_d = cell_q[0];
        end
        default: sel = SEL_HOLD;
      endcase
    end
  end

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_cell
    logic from_r;
    logic from_l;
    if (i == 0) begin : g_r_edge
      assign from_r = edge_r;
    end else begin : g_r_nbr
      assign from_r = cell_q[i-1];
    end
    if (i == WIDTH - 1) begin : g_l_edge
      assign from_l = edge_l;
    end else begin : g_l_nbr
      assign from_l = cell_q[i+1];
    end
    usr_bit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst),
      .sel_i    (sel),
      .d_i      (D[i]),
      .from_r_i (from_r),
      .from_l_i (from_l),
      .q_o      (cell_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_SHL;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !ld) begin
            mode_q <= mode;
            cnt_q  <= shamt;
            if (shamt != '0) begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          sout_q <= sout_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = cell_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg at WIDTH=8
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, clr, ld, start, sin_r, sin_l;
  logic [7:0] D;
  logic [2:0] mode;
  logic [3:0] shamt;
  logic [7:0] Q;
  logic       sout, busy, done;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  logic [7:0] q_model;
  logic       sout_model;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .ld    (ld),
    .D     (D),
    .start (start),
    .mode  (mode),
    .shamt (shamt),
    .sin_r (sin_r),
    .sin_l (sin_l),
    .Q     (Q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model_step(input logic [7:0] q, input logic [2:0] m,
                                            input logic sr, input logic sl, input logic s);
    case (m)
      3'b000:  return {q[7], (q << 1) | {7'b0, sr}};
      3'b001:  return {q[0], (q >> 1) | {sl, 7'b0}};
      3'b010:  return {q[7], (q << 1) | (q >> 7)};
      3'b011:  return {q[0], (q >> 1) | (q << 7)};
      3'b100:  return {q[0], 8'($signed(q) >>> 1)};
      default: return {s, q};
    endcase
  endfunction

  task automatic load(input logic [7:0] d);
    ld = 1'b1;
    D  = d;
    tick();
    ld = 1'b0;
    q_model = d;
    check_eq("load_q", Q, d);
  endtask

  task automatic run_op(input string tag, input logic [2:0] m, input logic [3:0] n,
                        input logic sr, input logic sl, input bit disturb);
    logic [8:0] st;
    logic [8:0] e;
    int busy_cnt;
    mode  = m;
    shamt = n;
    sin_r = sr;
    sin_l = sl;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_q_at_start"}, Q, q_model);
    st = {sout_model, q_model};
    for (int k = 0; k < int'(n); k++) begin
      st = model_step(st[7:0], m, sr, sl, st[8]);
      exp_q.push_back(st);
    end
    if (disturb) begin
      ld    = 1'b1;
      D     = 8'h00;
      start = 1'b1;
    end
    busy_cnt = 0;
    for (int k = 0; k < int'(n); k++) begin
      if (busy) busy_cnt++;
      check_eq({tag, "_done_early"}, done, 1'b0);
      tick();
      e = exp_q.pop_front();
      check_eq({tag, "_step_q"}, Q, e[7:0]);
      check_eq({tag, "_step_sout"}, sout, e[8]);
    end
    ld    = 1'b0;
    start = 1'b0;
    check_eq({tag, "_busy_cycles"}, busy_cnt, n);
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_busy_in_done"}, busy, 1'b0);
    q_model    = st[7:0];
    sout_model = st[8];
    tick();
    check_eq({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; ld = 1'b0; start = 1'b0;
    sin_r = 1'b0; sin_l = 1'b0; D = '0; mode = '0; shamt = '0;
    q_model = '0; sout_model = 1'b0;
    tick();
    tick();
    check_eq("rst_q", Q, 8'h00);
    check_eq("rst_sout", sout, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    rst = 1'b1;
    tick();

    // Asynchronous reset between edges
    load(8'hFF);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_q", Q, 8'h00);
    check_eq("async_rst_busy", busy, 1'b0);
    check_eq("async_rst_done", done, 1'b0);
    rst = 1'b1;
    q_model = '0; sout_model = 1'b0;
    tick();

    load(8'hAA);
    run_op("shl_ld_ignored", 3'b000, 4'd2, 1'b0, 1'b0, 1'b1);
    check_eq("shl_ld_ignored_final", Q, 8'hA8);

    load(8'hA5);
    run_op("shl3", 3'b000, 4'd3, 1'b1, 1'b0, 1'b0);
    check_eq("shl3_final", Q, 8'h2F);
    check_eq("shl3_sout", sout, 1'b1);

    load(8'h81);
    run_op("ror1", 3'b011, 4'd1, 1'b0, 1'b0, 1'b0);
    check_eq("ror1_final", Q, 8'hC0);

    load(8'h81);
    run_op("rol8", 3'b010, 4'd8, 1'b0, 1'b0, 1'b0);
    check_eq("rol8_final", Q, 8'h81);

    load(8'h90);
    run_op("asr2", 3'b100, 4'd2, 1'b0, 1'b0, 1'b0);
    check_eq("asr2_final", Q, 8'hE4);
    check_eq("asr2_sout", sout, 1'b0);

    run_op("reserved3", 3'b111, 4'd3, 1'b1, 1'b1, 1'b0);
    check_eq("reserved3_final", Q, 8'hE4);

    run_op("shamt0", 3'b000, 4'd0, 1'b1, 1'b0, 1'b0);
    check_eq("shamt0_final", Q, 8'hE4);

    run_op("shr12", 3'b001, 4'd12, 1'b0, 1'b1, 1'b0);
    check_eq("shr12_final", Q, 8'hFF);

    // Abort a 5-step SHR with clr at the second step edge
    load(8'hC3);
    mode  = 3'b001;
    shamt = 4'd5;
    sin_l = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("abort_busy", busy, 1'b1);
    tick();
    check_eq("abort_step1_q", Q, 8'h61);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("abort_q", Q, 8'h00);
    check_eq("abort_busy_low", busy, 1'b0);
    check_eq("abort_done_low", done, 1'b0);
    tick();
    check_eq("abort_no_done", done, 1'b0);
    check_eq("abort_idle_busy", busy, 1'b0);
    q_model    = 8'h00;
    sout_model = 1'b1;
    run_op("after_abort", 3'b000, 4'd1, 1'b1, 1'b0, 1'b0);
    check_eq("after_abort_final", Q, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
